// File: rtl/rf_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_pkg
// Shared types and constants for the register-file write-port arbiter.
//   RF_ADDR_W : register-file address width (32 architectural registers)
//   XLEN      : register data width
//   lu_wb_t   : one buffered long-latency-unit result (destination + data)
// ---------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int XLEN      = 32;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } lu_wb_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_if
// Bundles every non-clock signal of rf_wb_arbiter.
//   WB group  : i_wb_we, i_wb_rd, i_wb_data          (pipeline writeback)
//   LU group  : i_lu_valid, i_lu_rd, i_lu_data, o_lu_ready
//   ID group  : i_id_valid, i_id_rs1/rs2/rd, i_id_use_rs1/rs2, i_id_issue_lu
//   Outputs   : o_stall, o_reg_we, o_write_reg, o_write_reg_data, o_busy
// Modports: master = the surrounding pipeline, slave = the arbiter.
//
// LU handshake: a result transfers on a rising edge where i_lu_valid and
// o_lu_ready are both high. The producer holds i_lu_valid and its payload
// stable until that edge; o_lu_ready depends only on registered FIFO
// occupancy, never on i_lu_valid.
// ---------------------------------------------------------------------------
interface rf_wb_arbiter_if;
   import rf_wb_arbiter_pkg::*;

   logic                 i_wb_we;
   logic [RF_ADDR_W-1:0] i_wb_rd;
   logic [XLEN-1:0]      i_wb_data;

   logic                 i_lu_valid;
   logic [RF_ADDR_W-1:0] i_lu_rd;
   logic [XLEN-1:0]      i_lu_data;
   logic                 o_lu_ready;

   logic                 i_id_valid;
   logic [RF_ADDR_W-1:0] i_id_rs1;
   logic [RF_ADDR_W-1:0] i_id_rs2;
   logic [RF_ADDR_W-1:0] i_id_rd;
   logic                 i_id_use_rs1;
   logic                 i_id_use_rs2;
   logic                 i_id_issue_lu;

   logic                 o_stall;
   logic                 o_reg_we;
   logic [RF_ADDR_W-1:0] o_write_reg;
   logic [XLEN-1:0]      o_write_reg_data;
   logic [XLEN-1:0]      o_busy;

   modport master (
      output i_wb_we, i_wb_rd, i_wb_data,
      output i_lu_valid, i_lu_rd, i_lu_data,
      input  o_lu_ready,
      output i_id_valid, i_id_rs1, i_id_rs2, i_id_rd,
      output i_id_use_rs1, i_id_use_rs2, i_id_issue_lu,
      input  o_stall, o_reg_we, o_write_reg, o_write_reg_data, o_busy
   );

   modport slave (
      input  i_wb_we, i_wb_rd, i_wb_data,
      input  i_lu_valid, i_lu_rd, i_lu_data,
      output o_lu_ready,
      input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rd,
      input  i_id_use_rs1, i_id_use_rs2, i_id_issue_lu,
      output o_stall, o_reg_we, o_write_reg, o_write_reg_data, o_busy
   );

endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of lu_wb_t entries holding LU results until the register
// file write port is free.
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_push, i_push_data : enqueue (ignored when full)
//   i_pop           : dequeue the head (ignored when empty)
//   o_full, o_empty : occupancy flags from registered state
//   o_head          : current head entry (valid when !o_empty)
//   o_count         : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module wb_fifo
   import rf_wb_arbiter_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  lu_wb_t           i_push_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output lu_wb_t           o_head,
   output logic [CNT_W-1:0] o_count
);

   lu_wb_t           mem_q [DEPTH];
   lu_wb_t           mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign o_full  = (count_q == CNT_W'(DEPTH));
   assign o_empty = (count_q == '0);
   assign o_head  = mem_q[rd_ptr_q];
   assign o_count = count_q;

   assign do_push = i_push & ~o_full;
   assign do_pop  = i_pop & ~o_empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = i_push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the single register-file write port between pipeline writeback and
// the long-latency unit (LU), and keeps a scoreboard of registers that still
// have an LU write outstanding so decode can stall on RAW/WAW hazards.
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   bus (slave)      : WB / LU / decode inputs, port + stall + busy outputs
//   o_dbg_lu_count   : current LU FIFO occupancy, for observation only
// An effective WB write (we=1, rd!=0) always owns the port; otherwise the
// FIFO head drains. LU results for x0 are accepted but never stored.
// ---------------------------------------------------------------------------
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   rf_wb_arbiter_if.slave         bus,
   output logic [$clog2(DEPTH):0] o_dbg_lu_count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             wb_eff;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   lu_wb_t           fifo_head;
   lu_wb_t           push_data;
   logic [CNT_W-1:0] fifo_count;

   logic [31:1]      busy_q, busy_d;
   logic [31:0]      busy_vec;
   logic             stall;
   logic             lu_issue;

   logic                 reg_we;
   logic [RF_ADDR_W-1:0] write_reg;
   logic [XLEN-1:0]      write_data;

   assign wb_eff     = bus.i_wb_we & (bus.i_wb_rd != '0);
   // Handshake completes for x0 results too; they are simply not stored.
   assign fifo_push  = bus.i_lu_valid & ~fifo_full & (bus.i_lu_rd != '0);
   assign fifo_pop   = ~fifo_empty & ~wb_eff;
   assign push_data  = '{rd: bus.i_lu_rd, data: bus.i_lu_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (fifo_push),
      .i_push_data (push_data),
      .i_pop       (fifo_pop),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty),
      .o_head      (fifo_head),
      .o_count     (fifo_count)
   );

   // Stall uses registered busy only; the rd term blocks WAW on any opcode.
   assign busy_vec = {busy_q, 1'b0};
   assign stall    = bus.i_id_valid &
                     ((bus.i_id_use_rs1 & busy_vec[bus.i_id_rs1]) |
                      (bus.i_id_use_rs2 & busy_vec[bus.i_id_rs2]) |
                      busy_vec[bus.i_id_rd]);
   assign lu_issue = bus.i_id_valid & bus.i_id_issue_lu & ~stall &
                     (bus.i_id_rd != '0);

   // The WAW stall keeps set and clear of one bit from ever colliding.
   always_comb begin
      busy_d = busy_q;
      if (fifo_pop && fifo_head.rd != '0) begin
         busy_d[fifo_head.rd] = 1'b0;
      end
      if (lu_issue) begin
         busy_d[bus.i_id_rd] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Port mux is combinational; reset forces it idle so nothing reaches
   // the register file while the design is held in reset.
   always_comb begin
      reg_we     = 1'b0;
      write_reg  = '0;
      write_data = '0;
      if (!i_rst) begin
         if (wb_eff) begin
            reg_we     = 1'b1;
            write_reg  = bus.i_wb_rd;
            write_data = bus.i_wb_data;
         end else if (!fifo_empty) begin
            reg_we     = 1'b1;
            write_reg  = fifo_head.rd;
            write_data = fifo_head.data;
         end
      end
   end

   assign bus.o_reg_we         = reg_we;
   assign bus.o_write_reg      = write_reg;
   assign bus.o_write_reg_data = write_data;
   assign bus.o_lu_ready       = ~fifo_full;
   assign bus.o_stall          = stall;
   assign bus.o_busy           = busy_vec;
   assign o_dbg_lu_count       = fifo_count;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Directed scenarios followed by randomized traffic, all compared against a
// queue-based reference model of the write-port arbiter and scoreboard.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;
   import rf_wb_arbiter_pkg::*;

   localparam int DEPTH = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [$clog2(DEPTH):0] dbg_count;

   rf_wb_arbiter_if bus ();

   rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .bus            (bus),
      .o_dbg_lu_count (dbg_count)
   );

   // ---------------- scoreboard / model state ----------------
   int          n_vec  = 0;
   int          n_miss = 0;
   logic [36:0] exp_q[$];    // buffered LU results {rd, data}, head first
   logic [31:0] m_busy;      // registers with an LU write outstanding
   logic [36:0] lu_pend[$];  // LU stub: issued ops awaiting their result
   logic        step_acc;
   logic        step_issue;

   task automatic check_val(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      bus.i_wb_we       = 1'b0;
      bus.i_wb_rd       = '0;
      bus.i_wb_data     = '0;
      bus.i_lu_valid    = 1'b0;
      bus.i_lu_rd       = '0;
      bus.i_lu_data     = '0;
      bus.i_id_valid    = 1'b0;
      bus.i_id_rs1      = '0;
      bus.i_id_rs2      = '0;
      bus.i_id_rd       = '0;
      bus.i_id_use_rs1  = 1'b0;
      bus.i_id_use_rs2  = 1'b0;
      bus.i_id_issue_lu = 1'b0;
   endtask

   task automatic drive_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
      bus.i_wb_we   = we;
      bus.i_wb_rd   = rd;
      bus.i_wb_data = d;
   endtask

   task automatic drive_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      bus.i_lu_valid = v;
      bus.i_lu_rd    = rd;
      bus.i_lu_data  = d;
   endtask

   task automatic drive_id(input logic v, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2,
                           input logic [4:0] rd, input logic lu);
      bus.i_id_valid    = v;
      bus.i_id_rs1      = rs1;
      bus.i_id_use_rs1  = u1;
      bus.i_id_rs2      = rs2;
      bus.i_id_use_rs2  = u2;
      bus.i_id_rd       = rd;
      bus.i_id_issue_lu = lu;
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled 3
   // units later, well clear of both edges.
   task automatic settle();
      #3;
   endtask

   // Compare all outputs with the model, then advance one clock and apply
   // the model's state update for that edge.
   task automatic step();
      logic        wb_eff, exp_ready, exp_stall, exp_we, pop, acc, issue;
      logic [4:0]  exp_reg, popped_rd, id_rd, lu_rd;
      logic [31:0] exp_data, lu_data;
      logic [36:0] head;
      wb_eff    = bus.i_wb_we && (bus.i_wb_rd != 5'd0);
      exp_ready = (exp_q.size() < DEPTH);
      exp_stall = bus.i_id_valid && ((bus.i_id_use_rs1 && m_busy[bus.i_id_rs1]) ||
                                     (bus.i_id_use_rs2 && m_busy[bus.i_id_rs2]) ||
                                     m_busy[bus.i_id_rd]);
      exp_we = 1'b0; exp_reg = '0; exp_data = '0;
      if (wb_eff) begin
         exp_we = 1'b1; exp_reg = bus.i_wb_rd; exp_data = bus.i_wb_data;
      end else if (exp_q.size() > 0) begin
         head = exp_q[0];
         exp_we = 1'b1; exp_reg = head[36:32]; exp_data = head[31:0];
      end
      check_val("lu_ready", 32'(bus.o_lu_ready), 32'(exp_ready));
      check_val("stall", 32'(bus.o_stall), 32'(exp_stall));
      check_val("reg_we", 32'(bus.o_reg_we), 32'(exp_we));
      check_val("write_reg", 32'(bus.o_write_reg), 32'(exp_reg));
      check_val("write_data", bus.o_write_reg_data, exp_data);
      check_val("busy", bus.o_busy, m_busy);
      check_val("lu_count", 32'(dbg_count), 32'(exp_q.size()));

      pop   = !wb_eff && (exp_q.size() > 0);
      acc   = bus.i_lu_valid && exp_ready;
      issue = bus.i_id_valid && bus.i_id_issue_lu && !exp_stall;
      id_rd   = bus.i_id_rd;
      lu_rd   = bus.i_lu_rd;
      lu_data = bus.i_lu_data;

      @(posedge clk);
      #1;
      popped_rd = '0;
      if (pop) begin
         head = exp_q.pop_front();
         popped_rd = head[36:32];
         m_busy[popped_rd] = 1'b0;
      end
      if (issue && id_rd != 5'd0) begin
         check_val("set_clr", 32'(pop && popped_rd == id_rd), 32'd0);
         m_busy[id_rd] = 1'b1;
      end
      if (acc && lu_rd != 5'd0) exp_q.push_back({lu_rd, lu_data});
      step_acc   = acc;
      step_issue = issue;
   endtask

   // Asserted asynchronously, away from any edge; outputs must be at reset
   // values one time unit later even with live inputs.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_val("rst_reg_we", 32'(bus.o_reg_we), 32'd0);
      check_val("rst_write_reg", 32'(bus.o_write_reg), 32'd0);
      check_val("rst_write_data", bus.o_write_reg_data, 32'd0);
      check_val("rst_lu_ready", 32'(bus.o_lu_ready), 32'd1);
      check_val("rst_stall", 32'(bus.o_stall), 32'd0);
      check_val("rst_busy", bus.o_busy, 32'd0);
      check_val("rst_lu_count", 32'(dbg_count), 32'd0);
      exp_q.delete();
      lu_pend.delete();
      m_busy = '0;
      idle_inputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] d;
      int          idx;
      idle_inputs();
      m_busy = '0;
      step_acc = 1'b0;
      step_issue = 1'b0;
      rst = 1'b0;
      #2;
      do_reset();

      // LU op to x5, result 0x1234 three cycles later, dependent add waits.
      drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
      settle(); step();
      for (int c = 1; c <= 5; c++) begin
         drive_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b0);
         drive_lu(c == 3, (c == 3) ? 5'd5 : 5'd0, (c == 3) ? 32'h1234 : 32'h0);
         settle();
         check_val("tp1_busy5", 32'(bus.o_busy[5]), (c <= 4) ? 32'd1 : 32'd0);
         check_val("tp1_stall", 32'(bus.o_stall), (c <= 4) ? 32'd1 : 32'd0);
         if (c == 4) begin
            check_val("tp1_wr_reg", 32'(bus.o_write_reg), 32'd5);
            check_val("tp1_wr_data", bus.o_write_reg_data, 32'h1234);
         end
         step();
      end
      idle_inputs();
      settle(); step();

      // LU x7 arrives while WB writes x3 on two consecutive cycles.
      drive_wb(1'b1, 5'd3, 32'hAAAA_0001);
      drive_lu(1'b1, 5'd7, 32'h7777_0007);
      settle(); check_val("tp2_c0_reg", 32'(bus.o_write_reg), 32'd3); step();
      drive_lu(1'b0, 5'd0, 32'h0);
      drive_wb(1'b1, 5'd3, 32'hAAAA_0002);
      settle(); check_val("tp2_c1_reg", 32'(bus.o_write_reg), 32'd3); step();
      drive_wb(1'b0, 5'd0, 32'h0);
      settle();
      check_val("tp2_c2_reg", 32'(bus.o_write_reg), 32'd7);
      check_val("tp2_c2_data", bus.o_write_reg_data, 32'h7777_0007);
      step();
      settle(); step();

      // Continuous WB for 4 cycles with 3 LU results offered.
      idx = 0;
      for (int c = 0; c < 9; c++) begin
         drive_wb(c < 4, 5'(20 + c), $urandom);
         drive_lu(idx < 3, 5'(10 + idx), 32'h100 + 32'(idx));
         settle();
         if (c == 2) check_val("tp3_ready_full", 32'(bus.o_lu_ready), 32'd0);
         if (c >= 4 && c <= 6)
            check_val("tp3_order", 32'(bus.o_write_reg), 32'(10 + c - 4));
         step();
         if (step_acc) idx++;
      end
      idle_inputs();

      // LU result to x0 together with WB to x0.
      drive_wb(1'b1, 5'd0, 32'hDEAD_BEEF);
      drive_lu(1'b1, 5'd0, 32'hFEED_F00D);
      settle(); check_val("tp4_we_c0", 32'(bus.o_reg_we), 32'd0); step();
      idle_inputs();
      settle();
      check_val("tp4_we_c1", 32'(bus.o_reg_we), 32'd0);
      check_val("tp4_busy0", 32'(bus.o_busy[0]), 32'd0);
      step();

      // Reset with two buffered results and busy[9] set.
      drive_wb(1'b1, 5'd1, 32'h1);
      drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
      drive_lu(1'b1, 5'd12, 32'hC);
      settle(); step();
      drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      drive_lu(1'b1, 5'd13, 32'hD);
      settle(); step();
      drive_lu(1'b0, 5'd0, 32'h0);
      settle();
      check_val("tp5_busy9", 32'(bus.o_busy[9]), 32'd1);
      check_val("tp5_count", 32'(dbg_count), 32'd2);
      step();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         settle();
         check_val("tp5_nowrite", 32'(bus.o_reg_we), 32'd0);
         step();
      end

      // Randomized traffic with an in-order LU stub.
      for (int i = 0; i < 1500; i++) begin
         drive_wb(($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom);
         drive_id(($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
         if (!bus.i_lu_valid && lu_pend.size() > 0 && $urandom_range(0, 2) != 0) begin
            drive_lu(1'b1, lu_pend[0][36:32], lu_pend[0][31:0]);
         end
         if (i % 500 == 499) begin
            do_reset();
         end else begin
            settle();
            step();
            if (step_acc) begin
               void'(lu_pend.pop_front());
               drive_lu(1'b0, 5'd0, 32'h0);
            end
            if (step_issue) begin
               d = $urandom;
               lu_pend.push_back({bus.i_id_rd, d});
            end
         end
      end

      // Drain whatever remains so the tail of the queue is checked too.
      idle_inputs();
      for (int c = 0; c < 40; c++) begin
         if (!bus.i_lu_valid && lu_pend.size() > 0)
            drive_lu(1'b1, lu_pend[0][36:32], lu_pend[0][31:0]);
         settle();
         step();
         if (step_acc) begin
            void'(lu_pend.pop_front());
            drive_lu(1'b0, 5'd0, 32'h0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
